seg7_scan_driver: RTL and testbench
===================================

# seg7_scan_driver

Parametrised multiplexed seven-segment display driver. It decodes `NUM_DIGITS` packed hex nibbles to segment patterns and time-multiplexes them onto one shared segment bus with one enable per digit. Digit slots are separated by programmable dead time to suppress ghosting. Optional leading-zero blanking, per-digit blanking, per-digit decimal point and configurable output polarities are provided. It sits between the display-data producer (counters, status logic) and the board's segment/digit pins.

## Interface
- `NUM_DIGITS`, 4: number of multiplexed digits; legal 1..8.
- `SCAN_DIV`, 50000: clock cycles per digit slot; must be ≥ `BLANK_CYCLES`+1.
- `BLANK_CYCLES`, 2: dead-time cycles at the start of each slot; legal ≥ 0.
- `SEG_ACTIVE_LOW`, 0: 1 inverts `seg_out`.
- `DIG_ACTIVE_LOW`, 1: 1 inverts `dig_sel`.
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `digits_in`  in  4*NUM_DIGITS  hex nibbles; `[3:0]` is digit 0 (rightmost, least significant).
- `dp_in`  in  NUM_DIGITS  decimal point request, one bit per digit.
- `blank_in`  in  NUM_DIGITS  force digit fully dark, including the decimal point.
- `lzb_en`  in  1  enable leading-zero blanking.
- `load`  in  1  capture `digits_in`, `dp_in` and `blank_in` into the shadow registers.
- `seg_out`  out  8  segments `{a,b,c,d,e,f,g,dp}`, a = MSB, registered.
- `dig_sel`  out  NUM_DIGITS  one-hot digit enable, registered.
- `scan_idx`  out  max(1,clog2(NUM_DIGITS))  index of the digit currently being scanned.

## Operation
- **Shadow registers.** When `load`=1 at an edge, the shadow registers capture the inputs. The display always uses shadow data, so a frame never mixes old and new values within one capture. `lzb_en` is used live and is not shadowed.
- **Scan state.**
  - `div_cnt` counts 0..SCAN_DIV-1 and wraps.
  - When `div_cnt`=SCAN_DIV-1, `scan_idx` increments, wrapping from NUM_DIGITS-1 to 0.
  - With NUM_DIGITS=1, `scan_idx` stays at 0 and dead time still occurs in every slot.
- **Decode, active-high.** Patterns for 0..F:
  - 0–7: FC, 60, DA, F2, 66, B6, BE, E0.
  - 8–F: FE, F6, EE, 3E, 1A, 7A, 9E, 8E.
  - dp (bit 0) = `dp_in` shadow bit of the current digit.
- **Blanking priority:**
  1. Dead time (`div_cnt` < BLANK_CYCLES): all `dig_sel` inactive, `seg_out` all off.
  2. `blank_in` shadow bit set: digit enable active, all 8 segments off.
  3. Leading-zero blanking: with `lzb_en`=1, digit i≠0 has segments a–g off when digits i..NUM_DIGITS-1 are all zero. dp is preserved. Digit 0 is never leading-zero blanked.
  4. Otherwise the decoded pattern is driven.
- **Polarity.** Polarity inversion is applied last. "Off" means 0 for active-high and 1 for active-low; the same holds for `dig_sel`.
- **Reset values** (while `rst_n`=0 at an edge):
  - `div_cnt`=0, `scan_idx`=0.
  - Shadow registers all zero.
  - `seg_out` all off (00 active-high, FF active-low).
  - `dig_sel` all inactive.

## Timing
- **Output latency.** `seg_out` and `dig_sel` are registered from the scan state: the outputs in cycle t reflect `scan_idx`/`div_cnt` of cycle t-1. `scan_idx` itself is unregistered relative to the state, so it leads `dig_sel` by one cycle.
- **Frame timing.**
  - Frame length = NUM_DIGITS×SCAN_DIV cycles.
  - Each digit is enabled for SCAN_DIV−BLANK_CYCLES consecutive cycles per frame.
  - Exactly BLANK_CYCLES all-inactive cycles separate consecutive enables.
- **Load-to-output.** `load` sampled at edge k takes effect on `seg_out` after edge k+1. A mid-slot load may change segments within the slot; the scan timing is unaffected.
- **Reset after operation.** Reset asserted mid-frame takes effect at the next edge. After release, the first enabled digit is digit 0, which is enabled at the output starting BLANK_CYCLES+1 cycles after the first edge with `rst_n`=1.
- **Simultaneous events.** `load` coinciding with a slot wrap is captured normally; the new digit's first segment output uses the new data.

## Test plan
- **Reset.** Hold `rst_n`=0 for 3 cycles with random inputs → `seg_out`=00, `dig_sel`=0 (active-high config), `scan_idx`=0. Release → digit 0 enables after BLANK_CYCLES+1 cycles.
- **Decode sweep.** NUM_DIGITS=1, BLANK_CYCLES=0, SEG/DIG active-high. Load each of 0..F with dp=0 → `seg_out` is FC, 60, DA, F2, 66, B6, BE, E0, FE, F6, EE, 3E, 1A, 7A, 9E, 8E. Load 8 with dp=1 → FF.
- **Scan order and dead time.** NUM_DIGITS=4, SCAN_DIV=4, BLANK_CYCLES=1, DIG_ACTIVE_LOW=1 → `dig_sel` sequence per slot is F, E, E, E, then F, D, D, D, F, B, B, B, F, 7, 7, 7. The frame repeats every 16 cycles.
- **Leading-zero blanking.** Load 16'h0070, `lzb_en`=1, `dp_in`=4'b1000 → digit 3 `seg_out`=01, digit 2 = 00, digit 1 = E0, digit 0 = FC. With `lzb_en`=0, digits 3 and 2 show FD and FC.
- **Coherence and blanking.** Change `digits_in` every cycle without `load` → `seg_out` is unchanged. Pulse `load` with 16'h1234 → the new values appear 2 edges later. `blank_in`=4'b0100 → digit 2 reads 00 while still enabled.
- **Reset mid-frame.** Assert `rst_n`=0 while `scan_idx`=2 → `scan_idx`=0 at the next edge and the outputs are off. The shadow is cleared, so after release digit 0 shows FC.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment driver: shadowed hex digits are decoded and scanned
// one slot per digit onto a shared segment bus, with dead time between slots.
module seg7_scan_driver #(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 50000,
    parameter int BLANK_CYCLES   = 2,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit DIG_ACTIVE_LOW = 1'b1,
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic                    lzb_en,
    input  logic                    load,
    output logic [7:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   dig_sel,
    output logic [IDX_W-1:0]        scan_idx
);

    localparam int                DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [31:0]       BLANK_U  = 32'(BLANK_CYCLES);

    logic [DIV_W-1:0]        div_cnt_q, div_cnt_d;
    logic [IDX_W-1:0]        scan_idx_q, scan_idx_d;
    logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
    logic [NUM_DIGITS-1:0]   dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   blank_q, blank_d;
    logic [7:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   dig_q, dig_d;

    function automatic logic [7:0] decode(input logic [3:0] nib);
        logic [7:0] pat;
        case (nib)
            4'h0: pat = 8'hFC;
            4'h1: pat = 8'h60;
            4'h2: pat = 8'hDA;
            4'h3: pat = 8'hF2;
            4'h4: pat = 8'h66;
            4'h5: pat = 8'hB6;
            4'h6: pat = 8'hBE;
            4'h7: pat = 8'hE0;
            4'h8: pat = 8'hFE;
            4'h9: pat = 8'hF6;
            4'hA: pat = 8'hEE;
            4'hB: pat = 8'h3E;
            4'hC: pat = 8'h1A;
            4'hD: pat = 8'h7A;
            4'hE: pat = 8'h9E;
            default: pat = 8'h8E;
        endcase
        return pat;
    endfunction

    // State register: scan counters, shadow data and registered pin outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt_q  <= '0;
            scan_idx_q <= '0;
            digits_q   <= '0;
            dp_q       <= '0;
            blank_q    <= '0;
            seg_q      <= {8{SEG_ACTIVE_LOW}};
            dig_q      <= {NUM_DIGITS{DIG_ACTIVE_LOW}};
        end else begin
            div_cnt_q  <= div_cnt_d;
            scan_idx_q <= scan_idx_d;
            digits_q   <= digits_d;
            dp_q       <= dp_d;
            blank_q    <= blank_d;
            seg_q      <= seg_d;
            dig_q      <= dig_d;
        end
    end

    always_comb begin
        div_cnt_d  = div_cnt_q + DIV_W'(1);
        scan_idx_d = scan_idx_q;
        if (div_cnt_q == DIV_LAST) begin
            div_cnt_d  = '0;
            scan_idx_d = (scan_idx_q == IDX_LAST) ? '0 : scan_idx_q + IDX_W'(1);
        end
        digits_d = load ? digits_in : digits_q;
        dp_d     = load ? dp_in     : dp_q;
        blank_d  = load ? blank_in  : blank_q;
    end

    logic [NUM_DIGITS-1:0] lz_vec;
    logic                  zero_above;
    logic [3:0]            cur_nib;
    logic                  cur_dp, cur_blank, cur_lz, dead;
    logic [7:0]            seg_raw;
    logic [NUM_DIGITS-1:0] dig_raw;

    always_comb begin
        lz_vec     = '0;
        zero_above = 1'b1;
        cur_nib    = '0;
        cur_dp     = 1'b0;
        cur_blank  = 1'b0;
        cur_lz     = 1'b0;
        dig_raw    = '0;
        // A digit is a leading zero when it and every more significant digit are zero.
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above && (digits_q[4*i +: 4] == 4'h0);
            lz_vec[i]  = zero_above && (i != 0);
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (scan_idx_q == IDX_W'(i)) begin
                cur_nib    = digits_q[4*i +: 4];
                cur_dp     = dp_q[i];
                cur_blank  = blank_q[i];
                cur_lz     = lz_vec[i];
                dig_raw[i] = 1'b1;
            end
        end
        dead    = {{(32-DIV_W){1'b0}}, div_cnt_q} < BLANK_U;
        seg_raw = decode(cur_nib);
        if (lzb_en && cur_lz) seg_raw[7:1] = '0;
        seg_raw[0] = cur_dp;
        if (cur_blank) seg_raw = '0;
        if (dead) begin
            seg_raw = '0;
            dig_raw = '0;
        end
        seg_d = seg_raw ^ {8{SEG_ACTIVE_LOW}};
        dig_d = dig_raw ^ {NUM_DIGITS{DIG_ACTIVE_LOW}};
    end

    assign seg_out  = seg_q;
    assign dig_sel  = dig_q;
    assign scan_idx = scan_idx_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: three instances cover decode, scan timing,
// blanking, shadow coherence, polarity and reset behaviour.
module tb_seg7_scan_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // u_dec: single digit, no dead time, active-high everything
    logic        d_rst_n, d_lzb, d_load;
    logic [3:0]  d_digits;
    logic        d_dp, d_blank;
    logic [7:0]  d_seg;
    logic        d_dig;
    logic        d_idx;

    // u_main: 4 digits, 4-cycle slots, 1 dead cycle, active-low digit enables
    logic        m_rst_n, m_lzb, m_load;
    logic [15:0] m_digits;
    logic [3:0]  m_dp, m_blank;
    logic [7:0]  m_seg;
    logic [3:0]  m_dig;
    logic [1:0]  m_idx;

    // u_pol: 2 digits, 3-cycle slots, 2 dead cycles, active-low segments
    logic        p_rst_n, p_lzb, p_load;
    logic [7:0]  p_digits;
    logic [1:0]  p_dp, p_blank;
    logic [7:0]  p_seg;
    logic [1:0]  p_dig;
    logic        p_idx;

    seg7_scan_driver #(.NUM_DIGITS(1), .SCAN_DIV(2), .BLANK_CYCLES(0),
                       .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0)) u_dec (
        .clk(clk), .rst_n(d_rst_n), .digits_in(d_digits), .dp_in(d_dp),
        .blank_in(d_blank), .lzb_en(d_lzb), .load(d_load),
        .seg_out(d_seg), .dig_sel(d_dig), .scan_idx(d_idx));

    seg7_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(4), .BLANK_CYCLES(1),
                       .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b1)) u_main (
        .clk(clk), .rst_n(m_rst_n), .digits_in(m_digits), .dp_in(m_dp),
        .blank_in(m_blank), .lzb_en(m_lzb), .load(m_load),
        .seg_out(m_seg), .dig_sel(m_dig), .scan_idx(m_idx));

    seg7_scan_driver #(.NUM_DIGITS(2), .SCAN_DIV(3), .BLANK_CYCLES(2),
                       .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b0)) u_pol (
        .clk(clk), .rst_n(p_rst_n), .digits_in(p_digits), .dp_in(p_dp),
        .blank_in(p_blank), .lzb_en(p_lzb), .load(p_load),
        .seg_out(p_seg), .dig_sel(p_dig), .scan_idx(p_idx));

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] dec_tab [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                                 8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h1A, 8'h7A, 8'h9E, 8'h8E};
    logic [3:0] scan_tab [16] = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD,
                                  4'hF, 4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7};

    logic [7:0] frame_seg [4];
    logic [3:0] seen;
    logic       found;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic load_main();
        m_load = 1'b1;
        tick();
        m_load = 1'b0;
        tick();
    endtask

    // Record the segment value seen for each enabled digit over one 16-cycle frame.
    task automatic capture_frame(input bit scramble);
        seen = '0;
        for (int i = 0; i < 4; i++) frame_seg[i] = 8'h00;
        for (int c = 0; c < 16; c++) begin
            if (scramble) begin
                m_digits = 16'($urandom);
                m_dp     = 4'($urandom);
                m_blank  = 4'($urandom);
            end
            tick();
            for (int i = 0; i < 4; i++) begin
                if (m_dig[i] == 1'b0) begin
                    frame_seg[i] = m_seg;
                    seen[i]      = 1'b1;
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        d_rst_n = 1'b0; m_rst_n = 1'b0; p_rst_n = 1'b0;
        d_lzb = 1'b0; m_lzb = 1'b0; p_lzb = 1'b0;
        d_load = 1'b1; m_load = 1'b1; p_load = 1'b1;
        d_digits = 4'($urandom); d_dp = 1'($urandom); d_blank = 1'b0;
        m_digits = 16'($urandom); m_dp = 4'($urandom); m_blank = 4'($urandom);
        p_digits = 8'($urandom); p_dp = 2'($urandom); p_blank = 2'($urandom);
        for (int c = 0; c < 3; c++) begin
            tick();
            d_digits = 4'($urandom); m_digits = 16'($urandom); p_digits = 8'($urandom);
            m_lzb = 1'($urandom);
        end

        check("rst_m_seg", m_seg, 8'h00);
        check("rst_m_dig", m_dig, 4'hF);
        check("rst_m_idx", m_idx, 2'd0);
        check("rst_d_seg", d_seg, 8'h00);
        check("rst_d_dig", d_dig, 1'b0);
        check("rst_d_idx", d_idx, 1'b0);
        check("rst_p_seg", p_seg, 8'hFF);
        check("rst_p_dig", p_dig, 2'b00);
        check("rst_p_idx", p_idx, 1'b0);

        d_rst_n = 1'b1; m_rst_n = 1'b1; p_rst_n = 1'b1;
        d_load = 1'b0; m_load = 1'b0; p_load = 1'b0;
        d_digits = '0; d_dp = 1'b0;
        m_digits = '0; m_dp = '0; m_blank = '0; m_lzb = 1'b0;
        p_digits = '0; p_dp = '0; p_blank = '0;

        // Two frames of u_main scan; release timing of the other two instances.
        for (int j = 0; j < 32; j++) begin
            tick();
            check($sformatf("scan_dig_%0d", j), m_dig, scan_tab[j % 16]);
            check($sformatf("scan_idx_%0d", j), m_idx, ((j + 1) / 4) % 4);
            if (j == 0) begin
                check("rel_d_dig", d_dig, 1'b1);
                check("rel_d_seg", d_seg, 8'hFC);
            end
            if (j < 2) check($sformatf("rel_p_dead_%0d", j), p_dig, 2'b00);
            if (j == 2) begin
                check("rel_p_dig", p_dig, 2'b01);
                check("rel_p_seg", p_seg, 8'h03);
            end
        end

        for (int v = 0; v < 16; v++) begin
            d_digits = 4'(v);
            d_dp     = 1'b0;
            d_load   = 1'b1;
            tick();
            d_load = 1'b0;
            tick();
            check($sformatf("dec_%0h", v), d_seg, dec_tab[v]);
        end
        d_digits = 4'h8; d_dp = 1'b1; d_load = 1'b1;
        tick();
        d_load = 1'b0;
        tick();
        check("dec_8_dp", d_seg, 8'hFF);
        check("dec_dig_on", d_dig, 1'b1);

        m_digits = 16'h0070; m_dp = 4'b1000; m_blank = 4'b0000; m_lzb = 1'b1;
        load_main();
        capture_frame(1'b0);
        check("lzb_seen", seen, 4'hF);
        check("lzb_d3", frame_seg[3], 8'h01);
        check("lzb_d2", frame_seg[2], 8'h00);
        check("lzb_d1", frame_seg[1], 8'hE0);
        check("lzb_d0", frame_seg[0], 8'hFC);
        m_lzb = 1'b0;
        capture_frame(1'b0);
        check("nolzb_d3", frame_seg[3], 8'hFD);
        check("nolzb_d2", frame_seg[2], 8'hFC);

        capture_frame(1'b1);
        check("coh_d3", frame_seg[3], 8'hFD);
        check("coh_d2", frame_seg[2], 8'hFC);
        check("coh_d1", frame_seg[1], 8'hE0);
        check("coh_d0", frame_seg[0], 8'hFC);

        // Align to the dead cycle that opens digit 1's slot, then load mid-slot.
        found = 1'b0;
        for (int c = 0; c < 32 && !found; c++) begin
            tick();
            if (m_dig == 4'hF && m_idx == 2'd1) found = 1'b1;
        end
        check("sync_slot1", found, 1'b1);
        tick();
        m_digits = 16'h1234; m_dp = 4'b0000; m_blank = 4'b0000; m_load = 1'b1;
        tick();
        m_load = 1'b0;
        check("load_old_seg", m_seg, 8'hE0);
        check("load_old_dig", m_dig, 4'hD);
        tick();
        check("load_new_seg", m_seg, 8'hF2);
        check("load_new_dig", m_dig, 4'hD);
        capture_frame(1'b0);
        check("new_d0", frame_seg[0], 8'h66);
        check("new_d1", frame_seg[1], 8'hF2);
        check("new_d2", frame_seg[2], 8'hDA);
        check("new_d3", frame_seg[3], 8'h60);

        m_blank = 4'b0100;
        load_main();
        capture_frame(1'b0);
        check("blank_seen", seen, 4'hF);
        check("blank_d2", frame_seg[2], 8'h00);
        check("blank_d1", frame_seg[1], 8'hF2);

        found = 1'b0;
        for (int c = 0; c < 32 && !found; c++) begin
            tick();
            if (m_idx == 2'd2) found = 1'b1;
        end
        check("sync_idx2", found, 1'b1);
        m_rst_n = 1'b0;
        tick();
        check("midrst_idx", m_idx, 2'd0);
        check("midrst_dig", m_dig, 4'hF);
        check("midrst_seg", m_seg, 8'h00);
        m_rst_n = 1'b1;
        tick();
        check("midrel_dead", m_dig, 4'hF);
        tick();
        check("midrel_dig", m_dig, 4'hE);
        check("midrel_seg", m_seg, 8'hFC);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
